// File: rtl/wbr_pkg.sv
// Shared constants and helpers for the wrapper boundary register chain.
package wbr_pkg;

    localparam int unsigned SRC_W = 2;

    // cfo source selection shared by every cell in a segment
    localparam logic [SRC_W-1:0] SRC_FUNC = 2'd0;
    localparam logic [SRC_W-1:0] SRC_TEST = 2'd1;
    localparam logic [SRC_W-1:0] SRC_SAFE = 2'd2;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/wbr_cell.sv
// One dual-storage boundary cell: shift flop, update flop and cfo source mux.
module wbr_cell
    import wbr_pkg::*;
(
    input  logic             CLK,
    input  logic             reset,
    input  logic             si,
    input  logic             cfi,
    input  logic             shift_en,
    input  logic             capture_en,
    input  logic             update_en,
    input  logic [SRC_W-1:0] src_sel,
    input  logic             safe_bit,
    output logic             so,
    output logic             cfo
);

    logic sbit;
    logic ubit;

    // Shift has priority over capture; update copies the pre-edge shift bit.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sbit <= 1'b0;
        end else if (shift_en) begin
            sbit <= si;
        end else if (capture_en) begin
            sbit <= cfi;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            ubit <= 1'b0;
        end else if (update_en) begin
            ubit <= sbit;
        end
    end

    always_comb begin
        cfo = cfi;
        case (src_sel)
            SRC_TEST: cfo = ubit;
            SRC_SAFE: cfo = safe_bit;
            default:  cfo = cfi;
        endcase
    end

    assign so = sbit;

endmodule

// File: rtl/wbr_chain_sd2.sv
// IEEE 1500 boundary register segment: N_CELLS cells plus saturating shift counter.
module wbr_chain_sd2
    import wbr_pkg::*;
#(
    parameter int unsigned         N_CELLS    = 8,
    parameter logic [N_CELLS-1:0]  SAFE_VALUE = '0,
    parameter int unsigned         CNT_W      = cnt_width(N_CELLS)
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [N_CELLS-1:0] cfi,
    output logic [N_CELLS-1:0] cfo,
    input  logic               wsi,
    output logic               wso,
    input  logic               shift_en,
    input  logic               capture_en,
    input  logic               update_en,
    input  logic               test_mode,
    input  logic               safe_en,
    output logic [CNT_W-1:0]   shift_cnt,
    output logic               chain_full
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_CELLS);

    logic [SRC_W-1:0]   src_sel_c;
    logic [N_CELLS-1:0] so_bits;
    logic [N_CELLS-1:0] si_bits;
    logic [CNT_W-1:0]   cnt_nxt_c;

    always_comb begin
        src_sel_c = SRC_FUNC;
        if (safe_en) begin
            src_sel_c = SRC_SAFE;
        end else if (test_mode) begin
            src_sel_c = SRC_TEST;
        end
    end

    // Serial path runs from wsi at the top cell down to wso at cell 0.
    assign si_bits = {wsi, so_bits[N_CELLS-1:1]};
    assign wso     = so_bits[0];

    for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
        wbr_cell u_cell (
            .CLK        (CLK),
            .reset      (reset),
            .si         (si_bits[i]),
            .cfi        (cfi[i]),
            .shift_en   (shift_en),
            .capture_en (capture_en),
            .update_en  (update_en),
            .src_sel    (src_sel_c),
            .safe_bit   (SAFE_VALUE[i]),
            .so         (so_bits[i]),
            .cfo        (cfo[i])
        );
    end

    always_comb begin
        cnt_nxt_c = shift_cnt;
        if (shift_en) begin
            if (shift_cnt != CNT_MAX) begin
                cnt_nxt_c = shift_cnt + CNT_W'(1);
            end
        end else if (capture_en) begin
            cnt_nxt_c = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            shift_cnt  <= '0;
            chain_full <= 1'b0;
        end else begin
            shift_cnt  <= cnt_nxt_c;
            chain_full <= (cnt_nxt_c == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_wbr_chain_sd2.sv
// Directed vector bench for wbr_chain_sd2 with N_CELLS = 8 and SAFE_VALUE = 8'h0F.
module tb_wbr_chain_sd2;

    localparam int unsigned N     = 8;
    localparam int unsigned CW    = 4;
    localparam logic [N-1:0] SAFE = 8'h0F;

    logic          clk;
    logic          reset;
    logic [N-1:0]  cfi;
    logic [N-1:0]  cfo;
    logic          wsi;
    logic          wso;
    logic          shift_en;
    logic          capture_en;
    logic          update_en;
    logic          test_mode;
    logic          safe_en;
    logic [CW-1:0] shift_cnt;
    logic          chain_full;

    int checks;
    int errors;

    wbr_chain_sd2 #(.N_CELLS(N), .SAFE_VALUE(SAFE)) dut (
        .CLK        (clk),
        .reset      (reset),
        .cfi        (cfi),
        .cfo        (cfo),
        .wsi        (wsi),
        .wso        (wso),
        .shift_en   (shift_en),
        .capture_en (capture_en),
        .update_en  (update_en),
        .test_mode  (test_mode),
        .safe_en    (safe_en),
        .shift_cnt  (shift_cnt),
        .chain_full (chain_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst;
        logic          sh;
        logic          cap;
        logic          upd;
        logic          tm;
        logic          sf;
        logic          si;
        logic [N-1:0]  fi;
        logic          e_wso;
        logic [CW-1:0] e_cnt;
        logic          e_full;
        logic [N-1:0]  e_cfo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic rst, input logic sh, input logic cap,
                       input logic upd, input logic tm, input logic sf, input logic si,
                       input logic [N-1:0] fi, input logic e_wso, input logic [CW-1:0] e_cnt,
                       input logic e_full, input logic [N-1:0] e_cfo);
        vec_t v;
        v.name = nm; v.rst = rst; v.sh = sh; v.cap = cap; v.upd = upd; v.tm = tm;
        v.sf = sf; v.si = si; v.fi = fi; v.e_wso = e_wso; v.e_cnt = e_cnt;
        v.e_full = e_full; v.e_cfo = e_cfo;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic sh, input logic cap, input logic upd,
                         input logic tm, input logic sf, input logic si, input logic [N-1:0] fi);
        @(negedge clk);
        reset = rst; shift_en = sh; capture_en = cap; update_en = upd;
        test_mode = tm; safe_en = sf; wsi = si; cfi = fi;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string nm, input logic e_wso, input logic [CW-1:0] e_cnt,
                             input logic e_full, input logic [N-1:0] e_cfo);
        check({nm, ".wso"}, 32'(wso), 32'(e_wso));
        check({nm, ".cnt"}, 32'(shift_cnt), 32'(e_cnt));
        check({nm, ".full"}, 32'(chain_full), 32'(e_full));
        check({nm, ".cfo"}, 32'(cfo), 32'(e_cfo));
    endtask

    logic [N-1:0] pat_in;
    logic [N-1:0] pat_out;
    logic [N-1:0] got;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0; shift_en = 1'b0; capture_en = 1'b0; update_en = 1'b0;
        test_mode = 1'b0; safe_en = 1'b0; wsi = 1'b0; cfi = '0;

        //  name        rst sh cap upd tm sf si  cfi     wso cnt full cfo
        add("reset_all", 1, 1, 1, 1, 1, 0, 1, 8'hFF, 0, 0, 0, 8'h00);
        add("cap_a5",    0, 0, 1, 0, 0, 0, 0, 8'hA5, 1, 0, 0, 8'hA5);
        add("unl1",      0, 1, 0, 0, 0, 0, 0, 8'hA5, 0, 1, 0, 8'hA5);
        add("unl2",      0, 1, 0, 0, 0, 0, 0, 8'hA5, 1, 2, 0, 8'hA5);
        add("unl3",      0, 1, 0, 0, 0, 0, 0, 8'hA5, 0, 3, 0, 8'hA5);
        add("unl4",      0, 1, 0, 0, 0, 0, 0, 8'hA5, 0, 4, 0, 8'hA5);
        add("unl5",      0, 1, 0, 0, 0, 0, 0, 8'hA5, 1, 5, 0, 8'hA5);
        add("unl6",      0, 1, 0, 0, 0, 0, 0, 8'hA5, 0, 6, 0, 8'hA5);
        add("unl7",      0, 1, 0, 0, 0, 0, 0, 8'hA5, 1, 7, 0, 8'hA5);
        add("unl8",      0, 1, 0, 0, 0, 0, 0, 8'hA5, 0, 8, 1, 8'hA5);
        add("unl9_sat",  0, 1, 0, 0, 0, 0, 0, 8'hA5, 0, 8, 1, 8'hA5);
        // load 8'h3C: bits 0..7 shifted in as 0,0,1,1,1,1,0,0
        add("ld1",       0, 1, 0, 0, 0, 0, 0, 8'hA5, 0, 8, 1, 8'hA5);
        add("ld2",       0, 1, 0, 0, 0, 0, 0, 8'hA5, 0, 8, 1, 8'hA5);
        add("ld3",       0, 1, 0, 0, 0, 0, 1, 8'hA5, 0, 8, 1, 8'hA5);
        add("ld4",       0, 1, 0, 0, 0, 0, 1, 8'hA5, 0, 8, 1, 8'hA5);
        add("ld5",       0, 1, 0, 0, 0, 0, 1, 8'hA5, 0, 8, 1, 8'hA5);
        add("ld6",       0, 1, 0, 0, 0, 0, 1, 8'hA5, 0, 8, 1, 8'hA5);
        add("ld7",       0, 1, 0, 0, 0, 0, 0, 8'hA5, 0, 8, 1, 8'hA5);
        add("ld8",       0, 1, 0, 0, 0, 0, 0, 8'hA5, 0, 8, 1, 8'hA5);
        add("upd_3c",    0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 8, 1, 8'h3C);
        add("hold_ff",   0, 0, 0, 0, 1, 0, 0, 8'hFF, 0, 8, 1, 8'h3C);
        add("hold_55",   0, 0, 0, 0, 1, 0, 0, 8'h55, 0, 8, 1, 8'h3C);
        add("safe_on",   0, 0, 0, 0, 1, 1, 0, 8'h55, 0, 8, 1, 8'h0F);
        add("safe_off",  0, 0, 0, 0, 1, 0, 0, 8'h55, 0, 8, 1, 8'h3C);
        add("func_5a",   0, 0, 0, 0, 0, 0, 0, 8'h5A, 0, 8, 1, 8'h5A);
        add("reset2",    1, 0, 0, 0, 0, 0, 0, 8'h5A, 0, 0, 0, 8'h5A);
        add("prio",      0, 1, 1, 0, 0, 0, 1, 8'hFF, 0, 1, 0, 8'hFF);
        add("upd_80",    0, 0, 0, 1, 1, 0, 0, 8'hFF, 0, 1, 0, 8'h80);
        add("upd_shift", 0, 1, 0, 1, 1, 0, 0, 8'hFF, 0, 2, 0, 8'h80);
        add("upd_40",    0, 0, 0, 1, 1, 0, 0, 8'hFF, 0, 2, 0, 8'h40);
        add("cap_c3",    0, 0, 1, 0, 0, 0, 0, 8'hC3, 1, 0, 0, 8'hC3);
        add("mid1",      0, 1, 0, 0, 0, 0, 1, 8'hC3, 1, 1, 0, 8'hC3);
        add("mid2",      0, 1, 0, 0, 0, 0, 1, 8'hC3, 0, 2, 0, 8'hC3);
        add("mid3",      0, 1, 0, 0, 0, 0, 1, 8'hC3, 0, 3, 0, 8'hC3);
        add("mid4",      0, 1, 0, 0, 0, 0, 1, 8'hC3, 0, 4, 0, 8'hC3);
        add("mid_rst",   1, 0, 0, 0, 0, 0, 0, 8'hC3, 0, 0, 0, 8'hC3);
        add("upd_zero",  0, 0, 0, 1, 1, 0, 0, 8'hC3, 0, 0, 0, 8'h00);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].sh, vecs[i].cap, vecs[i].upd,
                  vecs[i].tm, vecs[i].sf, vecs[i].si, vecs[i].fi);
            check_all(vecs[i].name, vecs[i].e_wso, vecs[i].e_cnt, vecs[i].e_full, vecs[i].e_cfo);
        end

        // Combinational override without an intervening edge: ureg holds 8'h00 here
        @(negedge clk);
        safe_en = 1'b1; test_mode = 1'b1; update_en = 1'b0; cfi = 8'hAA;
        #1 check("comb_safe", 32'(cfo), 32'(SAFE));
        safe_en = 1'b0;
        #1 check("comb_test", 32'(cfo), 32'h00);
        test_mode = 1'b0;
        #1 check("comb_func", 32'(cfo), 32'hAA);

        // Full round trip: capture 8'h96, unload it while loading 8'h69, then update
        pat_in  = 8'h96;
        pat_out = 8'h69;
        got     = '0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pat_in);
        for (int k = 0; k < N; k++) begin
            got[k] = wso;
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pat_out[k], pat_in);
            check("rt_cnt", 32'(shift_cnt), 32'(k + 1));
        end
        check("rt_unload", 32'(got), 32'(pat_in));
        check("rt_full", 32'(chain_full), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("rt_update", 32'(cfo), 32'(pat_out));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
